// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debug_pkg
// Purpose  : Shared types and constants for the debug streaming fabric
//            (host-side frame metadata, UART arbiter state encoding and the
//            source-ID header base byte).
// Revision : 1.1 - arbiter state enum and header base constant added
// ============================================================================
package debug_pkg;

   // Metadata the host decoder extracts from one demultiplexed frame.
   typedef struct packed {
      logic [3:0] src_id;
      logic [7:0] length;
      logic       is_last;
   } parsed_meta;

   // Header byte base; the low nibble carries the source index.
   localparam logic [7:0] DBG_HDR_BASE = 8'hA0;

   // Debug UART arbiter states.
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_HEADER  = 2'd1,
      ARB_STREAM  = 2'd2,
      ARB_RELEASE = 2'd3
   } arb_state_t;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/debug_uart_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_select
// Purpose  : Combinational round-robin first-one finder. Returns the first
//            asserted request at or after ptr, wrapping modulo NUM_SRC.
// Revision : 1.0 - initial release
// ============================================================================
module rr_select #(
   parameter int NUM_SRC = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      idx,
   output logic               found
);

   // Position ptr+offset folded back into 0..NUM_SRC-1 (not a power-of-two wrap).
   function automatic logic [IW-1:0] wrap_pos(input logic [IW-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_SRC) sum = sum - NUM_SRC;
      return IW'(sum);
   endfunction

   // Scan from the farthest offset down so the nearest request wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (req[wrap_pos(ptr, k)]) begin
            idx   = wrap_pos(ptr, k);
            found = 1'b1;
         end
      end
   end

endmodule : rr_select
`default_nettype wire

// File: rtl/debug_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : debug_uart_arbiter
// Purpose  : Round-robin arbiter sharing one debug UART transmitter among
//            NUM_SRC byte-stream sources. Each granted burst is prefixed
//            with a source-ID header byte; the grant is held until last or
//            until the granted source has been idle for TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module debug_uart_arbiter
   import debug_pkg::*;
#(
   parameter int         NUM_SRC  = 4,
   parameter int         TIMEOUT  = 16,
   parameter logic [7:0] HDR_BASE = DBG_HDR_BASE
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [NUM_SRC*8-1:0]       src_data_in,
   input  logic [NUM_SRC-1:0]         src_valid_in,
   input  logic [NUM_SRC-1:0]         src_last_in,
   output logic [NUM_SRC-1:0]         src_ready_out,
   output logic [7:0]                 uart_tx_data,
   output logic                       uart_tx_valid,
   input  logic                       uart_tx_ready,
   output logic [$clog2(NUM_SRC)-1:0] grant_out,
   output logic                       busy_out
);

   localparam int GW = $clog2(NUM_SRC);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX   = '1;
   localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_SRC - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [GW-1:0] grant;
   logic [GW-1:0] grant_nxt;
   logic [GW-1:0] rr_ptr;
   logic [GW-1:0] rr_nxt;
   logic [CW-1:0] idle_cnt;
   logic [CW-1:0] cnt_nxt;

   logic [GW-1:0] sel_idx;
   logic          sel_found;

   logic [7:0]    src_byte [NUM_SRC];
   logic          grant_valid;
   logic          grant_last;
   logic [7:0]    grant_byte;

   // Unpack the flat data bus so the granted byte is a plain array lookup.
   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
         assign src_byte[i] = src_data_in[8*i +: 8];
      end
   endgenerate

   assign grant_valid = src_valid_in[grant];
   assign grant_last  = src_last_in[grant];
   assign grant_byte  = src_byte[grant];
   assign grant_out   = grant;

   rr_select #(
      .NUM_SRC (NUM_SRC),
      .IW      (GW)
   ) u_rr_select (
      .req   (src_valid_in),
      .ptr   (rr_ptr),
      .idx   (sel_idx),
      .found (sel_found)
   );

   // State register plus grant, round-robin pointer and idle counter.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= ARB_IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         rr_ptr   <= rr_nxt;
         idle_cnt <= cnt_nxt;
      end
   end

   // Next-state logic: grant selection, burst termination and idle timeout.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      cnt_nxt   = idle_cnt;
      case (state)
         ARB_IDLE: begin
            if (sel_found) begin
               grant_nxt = sel_idx;
               state_nxt = ARB_HEADER;
            end
         end
         ARB_HEADER: begin
            if (uart_tx_ready) begin
               cnt_nxt   = '0;
               state_nxt = ARB_STREAM;
            end
         end
         ARB_STREAM: begin
            if (grant_valid) begin
               // A stalled byte is backpressure, so the counter only moves on accept.
               if (uart_tx_ready) begin
                  cnt_nxt = '0;
                  if (grant_last) state_nxt = ARB_RELEASE;
               end
            end else if (idle_cnt >= CNT_LIMIT) begin
               state_nxt = ARB_RELEASE;
            end else if (idle_cnt != CNT_MAX) begin
               cnt_nxt = idle_cnt + 1'b1;
            end
         end
         ARB_RELEASE: begin
            rr_nxt    = (grant == LAST_IDX) ? '0 : grant + 1'b1;
            state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Output logic: header injection, then zero-latency pass-through of the granted source.
   always_comb begin
      uart_tx_valid = 1'b0;
      uart_tx_data  = '0;
      src_ready_out = '0;
      busy_out      = 1'b0;
      case (state)
         ARB_HEADER: begin
            uart_tx_valid = 1'b1;
            uart_tx_data  = HDR_BASE | 8'(grant);
            busy_out      = 1'b1;
         end
         ARB_STREAM: begin
            uart_tx_valid        = grant_valid;
            uart_tx_data         = grant_byte;
            src_ready_out[grant] = uart_tx_ready;
            busy_out             = 1'b1;
         end
         default: ;
      endcase
   end

endmodule : debug_uart_arbiter
`default_nettype wire

// File: tb/tb_debug_uart_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_uart_arbiter
// Purpose  : Self-checking bench for debug_uart_arbiter (4-source and
//            3-source instances). Sources are queue-driven; the expected
//            UART byte stream comes from directed constants or from a
//            frame-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debug_uart_arbiter;
   import debug_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rdy;
   logic [31:0] d4;
   logic [3:0]  v4, l4, r4;
   logic [7:0]  ud4;
   logic        uv4, b4;
   logic [1:0]  g4;
   logic [23:0] d3;
   logic [2:0]  v3, l3, r3;
   logic [7:0]  ud3;
   logic        uv3, b3;
   logic [1:0]  g3;

   debug_uart_arbiter #(.NUM_SRC(4), .TIMEOUT(16), .HDR_BASE(8'hA0)) dut4 (
      .clk_in(clk), .rst_n_in(rst_n), .src_data_in(d4), .src_valid_in(v4),
      .src_last_in(l4), .src_ready_out(r4), .uart_tx_data(ud4),
      .uart_tx_valid(uv4), .uart_tx_ready(rdy), .grant_out(g4), .busy_out(b4));

   debug_uart_arbiter #(.NUM_SRC(3), .TIMEOUT(16), .HDR_BASE(8'hA0)) dut3 (
      .clk_in(clk), .rst_n_in(rst_n), .src_data_in(d3), .src_valid_in(v3),
      .src_last_in(l3), .src_ready_out(r3), .uart_tx_data(ud3),
      .uart_tx_valid(uv3), .uart_tx_ready(rdy), .grant_out(g3), .busy_out(b3));

   // {last, data} per pending source byte; expected UART byte streams.
   logic [8:0] q4 [4][$];
   logic [8:0] q3 [3][$];
   logic [7:0] e4 [$];
   logic [7:0] e3 [$];
   bit         gap4 [4];
   bit         rand_rdy;

   // Observations of the most recent sampled cycle.
   logic       ob4, ob3, ov4, acc4, acc3;
   logic [7:0] od4;
   logic [1:0] og4;
   logic [3:0] sa4;
   logic [2:0] sa3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         src;
      int         len;
      logic [7:0] b [5];
   } frame_t;
   frame_t     mfr [$];
   logic [7:0] mexp [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      if (rand_rdy) rdy = ($urandom_range(9, 0) < 7);
      for (int i = 0; i < 4; i++) begin
         if (q4[i].size() > 0 && !gap4[i]) begin
            v4[i] = 1'b1; d4[8*i +: 8] = q4[i][0][7:0]; l4[i] = q4[i][0][8];
         end else begin
            v4[i] = 1'b0; d4[8*i +: 8] = 8'($urandom); l4[i] = 1'($urandom);
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (q3[i].size() > 0) begin
            v3[i] = 1'b1; d3[8*i +: 8] = q3[i][0][7:0]; l3[i] = q3[i][0][8];
         end else begin
            v3[i] = 1'b0; d3[8*i +: 8] = 8'($urandom); l3[i] = 1'($urandom);
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      ob4 = b4; ob3 = b3; ov4 = uv4; od4 = ud4; og4 = g4;
      acc4 = uv4 & rdy; acc3 = uv3 & rdy;
      sa4 = v4 & r4; sa3 = v3 & r3;
      if (acc4) begin
         if (e4.size() == 0) chk("dut4 unexpected uart byte", 32'(ud4), 32'hFFFF_FFFF);
         else chk("dut4 uart byte", 32'(ud4), 32'(e4.pop_front()));
      end
      if (acc3) begin
         if (e3.size() == 0) chk("dut3 unexpected uart byte", 32'(ud3), 32'hFFFF_FFFF);
         else chk("dut3 uart byte", 32'(ud3), 32'(e3.pop_front()));
      end
      chk("dut4 at most one source ready", 32'($onehot0(r4)), 1);
      chk("dut3 at most one source ready", 32'($onehot0(r3)), 1);
      if (sa4 != 4'd0) chk("dut4 source ack matches uart ack", 32'(acc4), 1);
      if (sa3 != 3'd0) chk("dut3 source ack matches uart ack", 32'(acc3), 1);
      chk("dut3 grant below 3", 32'(g3 < 2'd3), 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (sa4[i] && q4[i].size() > 0) void'(q4[i].pop_front());
      for (int i = 0; i < 3; i++) if (sa3[i] && q3[i].size() > 0) void'(q3[i].pop_front());
   endtask

   task automatic step();
      drive();
      sample();
   endtask

   function automatic bit pending();
      bit p = (e4.size() > 0) || (e3.size() > 0);
      for (int i = 0; i < 4; i++) if (q4[i].size() > 0) p = 1'b1;
      for (int i = 0; i < 3; i++) if (q3[i].size() > 0) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((pending() || ob4 || ob3) && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(pending() || ob4 || ob3), 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " dut4 valid"}, 32'(uv4), 0);
      chk({tag, " dut4 data"}, 32'(ud4), 0);
      chk({tag, " dut4 src ready"}, 32'(r4), 0);
      chk({tag, " dut4 grant"}, 32'(g4), 0);
      chk({tag, " dut4 busy"}, 32'(b4), 0);
      chk({tag, " dut3 valid"}, 32'(uv3), 0);
      chk({tag, " dut3 src ready"}, 32'(r3), 0);
      chk({tag, " dut3 busy"}, 32'(b3), 0);
   endtask

   // Frame-level reference: serve pending frames round-robin, wrapping mod n.
   task automatic run_model(input int n);
      bit used [64];
      int ptr = 0;
      int pick;
      mexp.delete();
      for (int f = 0; f < 64; f++) used[f] = 1'b0;
      for (int g = 0; g < mfr.size(); g++) begin
         pick = -1;
         for (int k = 0; k < n && pick < 0; k++) begin
            int s = (ptr + k) % n;
            for (int f = 0; f < mfr.size() && pick < 0; f++)
               if (!used[f] && mfr[f].src == s) pick = f;
         end
         mexp.push_back(DBG_HDR_BASE | 8'(mfr[pick].src));
         for (int j = 0; j < mfr[pick].len; j++) mexp.push_back(mfr[pick].b[j]);
         used[pick] = 1'b1;
         ptr = (mfr[pick].src + 1) % n;
      end
   endtask

   task automatic gen_frames(input int n, input int nf);
      mfr.delete();
      for (int f = 0; f < nf; f++) begin
         frame_t fr;
         fr.src = int'($urandom_range(n - 1, 0));
         fr.len = int'($urandom_range(5, 1));
         for (int j = 0; j < 5; j++) fr.b[j] = 8'($urandom);
         mfr.push_back(fr);
         for (int j = 0; j < fr.len; j++) begin
            if (n == 4) q4[fr.src].push_back({(j == fr.len - 1), fr.b[j]});
            else        q3[fr.src].push_back({(j == fr.len - 1), fr.b[j]});
         end
      end
   endtask

   initial begin
      int         n, hold, cnt_acc;
      bit         gap_done, early, started, busy_ok;
      logic [9:0] busy_pat;

      rst_n = 1'b0; rdy = 1'b1; rand_rdy = 1'b0;
      d4 = '0; v4 = '0; l4 = '0; d3 = '0; v3 = '0; l3 = '0;
      ob4 = 1'b0; ob3 = 1'b0;
      for (int i = 0; i < 4; i++) gap4[i] = 1'b0;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Sources 0 and 2 valid from reset; source 0 keeps a second frame pending.
      q4[0] = '{9'h001, 9'h102, 9'h103};
      q4[2] = '{9'h021, 9'h122};
      e4 = '{8'hA0, 8'h01, 8'h02, 8'hA2, 8'h21, 8'h22, 8'hA0, 8'h03};
      drain("two sources order", 100);

      // Source 1: two frames back-to-back, frame timing and regrant gap.
      q4[1] = '{9'h011, 9'h022, 9'h133, 9'h144};
      e4 = '{8'hA1, 8'h11, 8'h22, 8'h33, 8'hA1, 8'h44};
      busy_pat = '0;
      for (int c = 0; c < 10; c++) begin
         step();
         busy_pat = {busy_pat[8:0], ob4};
         if (c == 0) chk("idle cycle no uart valid", 32'(ov4), 0);
         if (c == 1) chk("header one cycle after request", 32'({ov4, od4}), 32'h1A1);
      end
      chk("busy pattern k+3 frame and regrant", 32'(busy_pat), 32'(10'b0111100110));
      chk("grant holds last source", 32'(og4), 1);
      drain("source 1 frames", 20);

      // rr_ptr is now 2: source 3 must win over source 1.
      q4[1] = '{9'h151};
      q4[3] = '{9'h171};
      e4 = '{8'hA3, 8'h71, 8'hA1, 8'h51};
      drain("rr pointer after release", 40);

      // pipe_probe-style gap after 8 bytes, no last, then timeout release.
      for (int i = 0; i < 16; i++) q4[0].push_back({1'b0, 8'(8'h40 + i)});
      e4.push_back(8'hA0);
      for (int i = 0; i < 16; i++) e4.push_back(8'(8'h40 + i));
      n = 0; cnt_acc = 0; gap_done = 1'b0; started = 1'b0; early = 1'b0;
      while (q4[0].size() > 0 && n < 200) begin
         gap4[0] = (cnt_acc == 8) && !gap_done;
         step();
         n++;
         if (gap4[0]) gap_done = 1'b1;
         if (sa4[0]) cnt_acc++;
         if (ob4) started = 1'b1;
         else if (started) early = 1'b1;
      end
      gap4[0] = 1'b0;
      chk("gapped stream not released early", 32'(early), 0);
      chk("gapped stream all bytes taken", 32'(cnt_acc), 16);
      hold = 0;
      step();
      while (ob4 && hold < 64) begin hold++; step(); end
      chk("timeout release 16 cycles after final byte", 32'(hold), 16);
      drain("timeout frame", 10);

      // Valid returns exactly when idle_cnt reaches TIMEOUT-1: accepted, no release.
      q4[2] = '{9'h061};
      e4 = '{8'hA2, 8'h61, 8'h62};
      n = 0;
      while (q4[2].size() > 0 && n < 20) begin step(); n++; end
      chk("boundary first byte accepted", 32'(q4[2].size()), 0);
      gap4[2] = 1'b1;
      q4[2].push_back(9'h162);
      busy_ok = 1'b1;
      for (int c = 0; c < 15; c++) begin step(); busy_ok = busy_ok & ob4; end
      chk("held through 15 idle cycles", 32'(busy_ok), 1);
      gap4[2] = 1'b0;
      step();
      chk("byte accepted at idle limit", 32'({ob4, sa4[2]}), 3);
      step();
      chk("release after last at idle limit", 32'(ob4), 0);
      drain("idle limit frame", 10);

      // Valid drops during header: empty frame released by timeout.
      q4[3] = '{9'h181};
      e4 = '{8'hA3};
      step();
      gap4[3] = 1'b1;
      hold = 0;
      step();
      while (ob4 && hold < 64) begin hold++; step(); end
      chk("empty frame busy cycles", 32'(hold), 17);
      q4[3].delete();
      gap4[3] = 1'b0;
      drain("empty frame", 10);

      // Backpressure: ready 1-of-4 with a 20-cycle stall, valid held high.
      for (int i = 0; i < 24; i++) q4[1].push_back({(i == 23), 8'(8'hC0 + i)});
      e4.push_back(8'hA1);
      for (int i = 0; i < 24; i++) e4.push_back(8'(8'hC0 + i));
      started = 1'b0; early = 1'b0;
      for (int c = 0; c < 100; c++) begin
         rdy = (c % 4 == 0) && !(c >= 40 && c < 60);
         step();
         if (ob4) started = 1'b1;
         else if (started && q4[1].size() > 0) early = 1'b1;
      end
      rdy = 1'b1;
      chk("no release under backpressure", 32'(early), 0);
      drain("backpressure frame", 100);

      // Reset during the second byte of source 3 (rr_ptr is 2 beforehand).
      q4[3] = '{9'h091, 9'h092, 9'h193};
      e4 = '{8'hA3, 8'h91};
      step(); step(); step();
      chk("reset test first byte taken", 32'(q4[3].size()), 2);
      drive();
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset("mid-frame reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      q4[3].delete();
      e4.delete();
      ob4 = 1'b0;
      q4[0] = '{9'h1A5};
      q4[3] = '{9'h1B5};
      e4 = '{8'hA0, 8'hA5, 8'hA3, 8'hB5};
      drain("fresh grant after reset", 40);

      // Three-source instance rotates 0,1,2,0.
      for (int i = 0; i < 3; i++) q3[i] = '{{1'b1, 8'(8'h30 + i)}, {1'b1, 8'(8'h30 + i)}};
      e3 = '{8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32, 8'hA0, 8'h30, 8'hA1, 8'h31, 8'hA2, 8'h32};
      drain("three-source rotation", 60);

      // Randomized frames and ready on both instances against the frame model.
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      gen_frames(4, 24);
      run_model(4);
      foreach (mexp[i]) e4.push_back(mexp[i]);
      gen_frames(3, 15);
      run_model(3);
      foreach (mexp[i]) e3.push_back(mexp[i]);
      rand_rdy = 1'b1;
      drain("random frames", 3000);
      rand_rdy = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "time limit");
   end

endmodule : tb_debug_uart_arbiter
`default_nettype wire

// File: doc/debug_uart_arbiter.md
# debug_uart_arbiter

Shares the single debug UART transmitter between up to NUM_SRC byte-stream debug sources: pipe_probe dump ports, status reporters and similar. The block grants one source at a time, round-robin. It prefixes each granted burst with a one-byte source-ID header so the host can demultiplex. It holds the grant until the source signals last or stays idle for TIMEOUT cycles, which tolerates the one-cycle valid gaps pipe_probe inserts between BRAM entries. It sits between the debug sources and the uart_tx instance.

## Interface
Parameters:
- NUM_SRC, 4: number of requesters; legal range 2..16.
- TIMEOUT, 16: consecutive idle cycles of the granted source before release; must be ≥ 2.
- HDR_BASE, 8'hA0: header byte is HDR_BASE | source index; low 4 bits of HDR_BASE must be 0.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_in  in  1  system clock.
  - rst_n_in  in  1  asynchronous active-low reset.
- Source side:
  - src_data_in  in  NUM_SRC*8  byte per source; source i occupies bits [8i+7:8i].
  - src_valid_in  in  NUM_SRC  source i has a byte.
  - src_last_in  in  NUM_SRC  current byte of source i ends its burst; qualified by valid.
  - src_ready_out  out  NUM_SRC  byte of source i accepted this cycle when valid & ready.
- UART side:
  - uart_tx_data  out  8  byte to transmitter.
  - uart_tx_valid  out  1  byte is valid.
  - uart_tx_ready  in  1  transmitter accepts when valid & ready.
- Status:
  - grant_out  out  $clog2(NUM_SRC)  index of the current/last granted source.
  - busy_out  out  1  high in HEADER or STREAM.

## Operation
- States: IDLE, HEADER, STREAM, RELEASE.
- IDLE:
  - uart_tx_valid=0, all src_ready_out=0.
  - If any src_valid_in is high, select the first valid index at or after rr_ptr (wrapping mod NUM_SRC), register it in grant_out, and go to HEADER.
- HEADER:
  - uart_tx_data = HDR_BASE | grant_out; uart_tx_valid=1; src_ready_out all 0.
  - On uart_tx_ready, clear idle_cnt and go to STREAM.
- STREAM:
  - Pure combinational pass-through: uart_tx_valid = src_valid_in[grant], uart_tx_data = src byte[grant], src_ready_out[grant] = uart_tx_ready; all other readies are 0.
  - On accept with src_last_in[grant] → RELEASE.
  - On accept without last → idle_cnt cleared.
  - While src_valid_in[grant]=0 → idle_cnt increments; when idle_cnt reaches TIMEOUT-1 with valid still low → RELEASE.
  - A valid byte with ready low is backpressure, not idle: idle_cnt holds.
- RELEASE (one cycle):
  - Outputs idle; rr_ptr ← (grant+1) mod NUM_SRC; go to IDLE.
  - This cycle guarantees other sources a fairness window.
- Arithmetic:
  - idle_cnt width is $clog2(TIMEOUT)+1 and saturates; it never wraps.
  - rr_ptr wraps at NUM_SRC, not at the power of two.
- Non-granted sources are never acknowledged; their valid may stay high indefinitely without loss.
- A source dropping valid in HEADER is still streamed (header already committed); if nothing arrives, the timeout releases it, giving an empty frame of header only.

## Timing
- Reset values: state=IDLE, rr_ptr=0, grant_out=0, idle_cnt=0, busy_out=0, uart_tx_valid=0, uart_tx_data=0, src_ready_out=0.
- Reset asserted mid-frame drops the frame immediately; no byte is acknowledged on the reset cycle.
- Latency, request to header: valid seen in IDLE at cycle N → header valid at N+1.
- Best-case frame of k bytes occupies k+3 cycles (IDLE, HEADER, k×STREAM, RELEASE).
- Stream bytes add zero cycles of latency; ready/valid are combinational through the block. No registered path exists on data in STREAM.
- The same source can be regranted at the earliest 2 cycles after RELEASE begins, if no other source requests.
- Simultaneous last and reset: reset wins.
- A timeout with valid rising in the same cycle as idle_cnt==TIMEOUT-1: the byte is accepted (if ready) and the counter clears; no release.

## Structure
- Shared package debug_pkg (already holds parsed_meta):
  - add arb_state_t enum;
  - add DBG_HDR_BASE constant; the host decoder uses the same value.
- Natural sub-module: rr_select (combinational round-robin first-one finder taking req vector and rr_ptr, returning index and found).
- The rest is one FSM with counter.

## Test plan
- Single source 1 sends 8'h11, 8'h22, 8'h33 (last on 33), ready always high: UART sees A1, 11, 22, 33; busy drops after RELEASE; rr_ptr=2.
- Sources 0 and 2 both valid from reset, each sends 2 bytes ending in last: order A0, src0 bytes, A2, src2 bytes; then source 0 requesting again gets grant only after source 2 releases.
- pipe_probe-style gaps, TIMEOUT=16: source streams with 1-cycle valid gaps every 8 bytes, no last: no release during the stream; release occurs exactly 16 cycles after the final byte.
- Backpressure: uart_tx_ready toggles 1-of-4 cycles for 100 cycles with valid held high: no timeout, no byte duplicated or lost, idle_cnt stays 0.
- Reset mid-frame: assert rst_n_in low during the 2nd byte of source 3: all outputs return to reset values asynchronously; after release the next grant starts from source 0 with a fresh header.
- NUM_SRC=3 wrap: grants rotate 0→1→2→0 with all valid; rr_ptr never reaches 3.
